// File: rtl/pipe_wb_regfile_pkg.sv
// rtl/pipe_wb_regfile_pkg.sv - shared pipeline constants, types and write-back select helper
package pipe_wb_regfile_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int REGW = 5;

  typedef logic [XLEN-1:0] word_t;
  typedef logic [REGW-1:0] regnum_t;

  // Write-back source encoding carried by wm2reg
  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_src_e;

  // Pick the write-back word; the unselected operand never reaches the result
  function automatic word_t wb_select(input logic m2reg, input word_t mo, input word_t alu);
    return (wb_src_e'(m2reg) == WB_MEM) ? mo : alu;
  endfunction

endpackage

// File: rtl/pipe_wb_regfile_if.sv
// rtl/pipe_wb_regfile_if.sv - write-back and register read bundle between pipeline and regfile
interface pipe_wb_regfile_if;
  import pipe_wb_regfile_pkg::*;

  logic    wwreg;
  logic    wm2reg;
  word_t   wmo;
  word_t   walu;
  regnum_t wrn;
  regnum_t rna;
  regnum_t rnb;
  word_t   qa;
  word_t   qb;
  word_t   wdi;

  // Pipeline side: drives write-back and read numbers, consumes read data
  modport master (
    output wwreg, wm2reg, wmo, walu, wrn, rna, rnb,
    input  qa, qb, wdi
  );

  // Register file side
  modport slave (
    input  wwreg, wm2reg, wmo, walu, wrn, rna, rnb,
    output qa, qb, wdi
  );

endinterface

// File: rtl/pipe_wb_regfile_regfile32.sv
// rtl/pipe_wb_regfile_regfile32.sv - 32x32 storage array with one write port and r0 masking
module regfile32
  import pipe_wb_regfile_pkg::*;
(
  input  logic    clk,
  input  logic    clrn,
  input  logic    we,
  input  regnum_t wn,
  input  word_t   d,
  input  regnum_t rna,
  input  regnum_t rnb,
  output word_t   qa,
  output word_t   qb
);

  word_t regs [NREG];

  // Async clear of every entry; r0 is never written so its slot stays zero
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (wn != '0)) begin
      regs[wn] <= d;
    end
  end

  // Stored read data with r0 forced to zero
  always_comb begin
    qa = (rna == '0) ? '0 : regs[rna];
    qb = (rnb == '0) ? '0 : regs[rnb];
  end

endmodule

// File: rtl/pipe_wb_regfile.sv
// rtl/pipe_wb_regfile.sv - write-back mux, register file and same-cycle write-through bypass
module pipe_wb_regfile
  import pipe_wb_regfile_pkg::*;
(
  input logic              clk,
  input logic              clrn,
  pipe_wb_regfile_if.slave wb
);

  word_t qa_store;
  word_t qb_store;

  regfile32 u_regfile32 (
    .clk  (clk),
    .clrn (clrn),
    .we   (wb.wwreg),
    .wn   (wb.wrn),
    .d    (wb.wdi),
    .rna  (wb.rna),
    .rnb  (wb.rnb),
    .qa   (qa_store),
    .qb   (qb_store)
  );

  // Write-back data select, independent of reset so ID-stage forwarding always sees it
  always_comb begin
    wb.wdi = wb_select(wb.wm2reg, wb.wmo, wb.walu);
  end

  // Read ports: r0 is zero, a matching in-flight write is bypassed, else stored value
  always_comb begin
    if (wb.rna == '0) begin
      wb.qa = '0;
    end else if (wb.wwreg && (wb.rna == wb.wrn)) begin
      wb.qa = wb.wdi;
    end else begin
      wb.qa = qa_store;
    end

    if (wb.rnb == '0) begin
      wb.qb = '0;
    end else if (wb.wwreg && (wb.rnb == wb.wrn)) begin
      wb.qb = wb.wdi;
    end else begin
      wb.qb = qb_store;
    end
  end

endmodule

// File: tb/tb_pipe_wb_regfile.sv
// tb/tb_pipe_wb_regfile.sv - directed and random checks of the write-back register file
module tb_pipe_wb_regfile;

  logic clk;
  logic clrn;
  int   nerr;
  int   nchk;
  logic [31:0] mdl [32];

  pipe_wb_regfile_if bus ();

  pipe_wb_regfile dut (
    .clk  (clk),
    .clrn (clrn),
    .wb   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_drive(input logic we, input logic m2r, input logic [31:0] mo,
                          input logic [31:0] alu, input logic [4:0] rn);
    bus.wwreg  = we;
    bus.wm2reg = m2r;
    bus.wmo    = mo;
    bus.walu   = alu;
    bus.wrn    = rn;
  endtask

  initial begin
    logic [31:0] wd;
    logic [31:0] ea;
    logic [31:0] eb;
    nerr = 0;
    nchk = 0;
    clrn = 1'b0;
    wb_drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    bus.rna = 5'd5;
    bus.rnb = 5'd5;
    #2;
    check("reset_qa", bus.qa, 32'h0);
    check("reset_qb", bus.qb, 32'h0);

    // Write r5 then clear it asynchronously mid-cycle
    tick();
    clrn = 1'b1;
    wb_drive(1'b1, 1'b0, 32'h0, 32'h1234, 5'd5);
    tick();
    bus.wwreg = 1'b0;
    #1;
    check("r5_written", bus.qa, 32'h1234);
    #2;
    clrn = 1'b0;
    #1;
    check("async_clear_qa", bus.qa, 32'h0);
    check("async_clear_qb", bus.qb, 32'h0);

    // Writes blocked in reset, bypass and wdi still live
    wb_drive(1'b1, 1'b0, 32'h0, 32'hAA, 5'd6);
    bus.rna = 5'd6;
    #1;
    check("reset_bypass_qa", bus.qa, 32'hAA);
    check("reset_wdi", bus.wdi, 32'hAA);
    tick();
    bus.wwreg = 1'b0;
    #1;
    check("reset_write_blocked", bus.qa, 32'h0);

    // Release mid-cycle: next edge writes normally
    #2;
    clrn = 1'b1;
    wb_drive(1'b1, 1'b0, 32'h0, 32'hBB, 5'd6);
    tick();
    bus.wwreg = 1'b0;
    #1;
    check("release_write", bus.qa, 32'hBB);

    // Memory source
    wb_drive(1'b1, 1'b1, 32'hDEADBEEF, 32'h11111111, 5'd7);
    bus.rna = 5'd1;
    #1;
    check("wdi_mem", bus.wdi, 32'hDEADBEEF);
    tick();
    bus.wwreg = 1'b0;
    bus.rna = 5'd7;
    #1;
    check("r7_mem", bus.qa, 32'hDEADBEEF);

    // ALU source
    wb_drive(1'b1, 1'b0, 32'hDEADBEEF, 32'h11111111, 5'd7);
    bus.rna = 5'd1;
    #1;
    check("wdi_alu", bus.wdi, 32'h11111111);
    tick();
    bus.wwreg = 1'b0;
    bus.rna = 5'd7;
    #1;
    check("r7_alu", bus.qa, 32'h11111111);

    // Unselected operand is X and must not leak
    wb_drive(1'b0, 1'b0, 32'hxxxxxxxx, 32'h0F0F0F0F, 5'd7);
    #1;
    check("wdi_x_wmo", bus.wdi, 32'h0F0F0F0F);
    wb_drive(1'b0, 1'b1, 32'hF0F0F0F0, 32'hxxxxxxxx, 5'd7);
    #1;
    check("wdi_x_walu", bus.wdi, 32'hF0F0F0F0);

    // Same-cycle bypass on both ports
    wb_drive(1'b1, 1'b0, 32'h0, 32'hCAFE0001, 5'd9);
    bus.rna = 5'd9;
    bus.rnb = 5'd9;
    #1;
    check("bypass_qa", bus.qa, 32'hCAFE0001);
    check("bypass_qb", bus.qb, 32'hCAFE0001);
    tick();
    bus.wwreg = 1'b0;
    #1;
    check("r9_stored_qa", bus.qa, 32'hCAFE0001);
    check("r9_stored_qb", bus.qb, 32'hCAFE0001);

    // r0 is immune to writes
    wb_drive(1'b1, 1'b0, 32'h0, 32'hFFFFFFFF, 5'd0);
    bus.rna = 5'd0;
    bus.rnb = 5'd0;
    #1;
    check("r0_wdi", bus.wdi, 32'hFFFFFFFF);
    check("r0_pre_qa", bus.qa, 32'h0);
    tick();
    #1;
    check("r0_post_qa", bus.qa, 32'h0);
    check("r0_post_qb", bus.qb, 32'h0);

    // Write disable keeps r3 and does not bypass
    wb_drive(1'b1, 1'b0, 32'h0, 32'h00000003, 5'd3);
    tick();
    wb_drive(1'b0, 1'b0, 32'h0, 32'h55, 5'd3);
    bus.rnb = 5'd3;
    #1;
    check("wdis_no_bypass", bus.qb, 32'h00000003);
    tick();
    #1;
    check("wdis_held", bus.qb, 32'h00000003);

    // Random regression from a clean reset
    clrn = 1'b0;
    #1;
    clrn = 1'b1;
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    for (int c = 0; c < 10000; c++) begin
      bus.wwreg  = ($urandom_range(0, 3) != 0);
      bus.wm2reg = $urandom_range(0, 1);
      bus.wmo    = $urandom;
      bus.walu   = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        bus.wrn = 5'($urandom_range(0, 7));
        bus.rna = 5'($urandom_range(0, 7));
        bus.rnb = 5'($urandom_range(0, 7));
      end else begin
        bus.wrn = 5'($urandom_range(0, 31));
        bus.rna = 5'($urandom_range(0, 31));
        bus.rnb = 5'($urandom_range(0, 31));
      end
      if ($urandom_range(0, 7) == 0) begin
        bus.rna = bus.wrn;
        bus.rnb = bus.wrn;
      end
      wd = bus.wm2reg ? bus.wmo : bus.walu;
      ea = (bus.rna == 5'd0) ? 32'h0 : ((bus.wwreg && bus.rna == bus.wrn) ? wd : mdl[bus.rna]);
      eb = (bus.rnb == 5'd0) ? 32'h0 : ((bus.wwreg && bus.rnb == bus.wrn) ? wd : mdl[bus.rnb]);
      #2;
      check("rand_qa", bus.qa, ea);
      check("rand_qb", bus.qb, eb);
      @(posedge clk);
      if (bus.wwreg && bus.wrn != 5'd0) mdl[bus.wrn] = wd;
      #1;
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/pipe_wb_regfile.md
PIPE_WB_REGFILE -- requirements
Module: pipe_wb_regfile

Interface
REQ-001 The block SHALL have input clk, 1 bit: clock; all state updates occur on the rising edge.
REQ-002 The block SHALL have input clrn, 1 bit: reset, asynchronous, active-low.
REQ-003 The block SHALL have input wwreg, 1 bit: write-back register-write enable from the MEM/WB register.
REQ-004 The block SHALL have input wm2reg, 1 bit: write-back source select; 1 = memory data, 0 = ALU result.
REQ-005 The block SHALL have input wmo, 32 bits: memory load data from the MEM/WB register.
REQ-006 The block SHALL have input walu, 32 bits: ALU result from the MEM/WB register.
REQ-007 The block SHALL have input wrn, 5 bits: destination register number.
REQ-008 The block SHALL have input rna, 5 bits: read port A register number (ID stage rs).
REQ-009 The block SHALL have input rnb, 5 bits: read port B register number (ID stage rt).
REQ-010 The block SHALL have output qa, 32 bits: read port A data.
REQ-011 The block SHALL have output qb, 32 bits: read port B data.
REQ-012 The block SHALL have output wdi, 32 bits: selected write-back data, exported for ID-stage forwarding.

Function
REQ-013 The block SHALL drive wdi = wm2reg ? wmo : walu combinationally.
REQ-014 The block SHALL hold 31 architectural 32-bit registers r1..r31; r0 SHALL read as 0 at all times.
REQ-015 On a rising clk edge with wwreg=1 and wrn!=0, the block SHALL store wdi into register wrn.
REQ-016 A write with wrn=0 SHALL be ignored, and r0 SHALL remain 0.
REQ-017 With wwreg=0, no register SHALL change.
REQ-018 qa SHALL be combinational: 0 if rna=0; wdi if wwreg=1 and rna=wrn (write-through bypass in the same cycle); otherwise register[rna].
REQ-019 qb SHALL follow the same rule as REQ-018 using rnb.
REQ-020 Both ports SHALL support simultaneous reads of the same register, with identical results.
REQ-021 Write latency SHALL be: data is visible on qa/qb in the same cycle through the bypass, and from storage starting the cycle after the edge.
REQ-022 No X SHALL propagate from unselected inputs: wmo SHALL be ignored when wm2reg=0, and walu SHALL be ignored when wm2reg=1.

Reset
REQ-023 clrn=0 SHALL immediately clear r1..r31 to 0, independent of clk.
REQ-024 While clrn=0, qa and qb SHALL read 0 except through the REQ-018 bypass, and writes SHALL be blocked.
REQ-025 When clrn deasserts mid-operation, the first rising edge at which clrn=1 SHALL perform a normal write.
REQ-026 wdi SHALL remain combinational and unaffected by clrn.

Structure
REQ-027 The shared pipeline package SHALL hold XLEN=32, NREG=32, and REGW=5; the block SHALL use these constants for all widths.
REQ-028 Storage SHALL be a single sub-module, regfile32, containing the array, the write port, and r0 masking.
REQ-029 The write-back mux and the bypass logic SHALL live in pipe_wb_regfile.
REQ-030 The block SHALL use no latches and no negative-edge writes.

Verification
REQ-031 The bench SHALL check reset: pulse clrn low mid-cycle after writing r5=0x1234, then read rna=5 -> qa=0 immediately, before any clk edge.
REQ-032 The bench SHALL check mux and write: wwreg=1, wm2reg=1, wmo=0xDEADBEEF, walu=0x11111111, wrn=7 -> wdi=0xDEADBEEF; after the edge, rna=7 -> qa=0xDEADBEEF. Repeat with wm2reg=0 -> r7=0x11111111.
REQ-033 The bench SHALL check the bypass: in the same cycle as a write of 0xCAFE0001 to r9, rna=9 and rnb=9 -> qa=qb=0xCAFE0001 before the edge.
REQ-034 The bench SHALL check r0: wwreg=1, wrn=0, walu=0xFFFFFFFF -> wdi=0xFFFFFFFF, but qa with rna=0 = 0 both before and after the edge.
REQ-035 The bench SHALL check write disable: r3=0x00000003, then wwreg=0, wrn=3, walu=0x55 for one edge -> rnb=3 gives qb=0x00000003 and no bypass.
REQ-036 The bench SHALL run a random regression of 10k cycles against a reference array model, checking qa/qb every cycle, including rna=rnb=wrn collisions.
